msrv_32_ifetch_unit: RTL and testbench
======================================

// Module: msrv_32_ifetch_unit
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register block. Takes the registered PC,
//  runs a req/ack transaction on the instruction-memory port, and buffers returned words in a small
//  FIFO. The FIFO feeds decode through a valid/ready handshake. pc_accept_out tells the PC mux to
//  advance; while it is low the PC holds. Flush discards everything fetched or in flight.
// PARAMETERS
//  FIFO_DEPTH  2             entries in the fetch buffer; power of two, >= 2
//  NOP_INSTR   32'h00000013  word substituted for misaligned fetches (addi x0,x0,0)
// PORTS
//  ms_risc32_mp_clk_in    in   1   clock; all state updates on the rising edge
//  ms_risc32_mp_rst_n_in  in   1   asynchronous, active-low reset
//  pc_in                  in   32  current PC, from the PC register block
//  pc_accept_out          out  1   comb.; pc_in consumed this cycle, so the PC mux may advance
//  flush_in               in   1   branch/jump redirect; kill buffered and in-flight fetches
//  imem_req_out           out  1   instruction-memory request
//  imem_addr_out          out  32  word-aligned fetch address, {pc[31:2],2'b00}
//  imem_ack_in            in   1   memory has returned imem_rdata_in this cycle
//  imem_rdata_in          in   32  instruction word
//  instr_valid_out        out  1   FIFO head valid
//  instr_ready_in         in   1   decode accepts the head
//  instr_out              out  32  instruction at the FIFO head
//  instr_pc_out           out  32  PC of that instruction
//  instr_misalign_out     out  1   head entry came from a PC with pc[1:0]!=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, FIFO empty; imem_req_out=0, imem_addr_out=0,
//   instr_valid_out=0, instr_out/instr_pc_out=0, instr_misalign_out=0, pc_accept_out=0.
//  States: IDLE (nothing in flight), REQ (one request outstanding), DRAIN (outstanding request
//   flushed; wait for ack).
//  pop = instr_valid_out & instr_ready_in.
//  credit_ok = (count + imem_req_out - pop) < FIFO_DEPTH. An in-flight request reserves one slot.
//  issue = !flush_in & credit_ok & pc_in[1:0]==0 & (state==IDLE | (state==REQ & imem_ack_in)).
//  On issue: pc_accept_out=1; at the next edge imem_req_out=1, imem_addr_out={pc_in[31:2],2'b00};
//   pc_in is captured as the tag; state goes to REQ.
//  REQ + ack: push {rdata, tag, 0}. If issue also holds, the next request starts at the same edge,
//   giving 1 fetch/cycle with zero-wait memory. Otherwise imem_req_out drops and state goes to IDLE.
//  REQ without ack: hold imem_req_out and imem_addr_out stable. Never withdraw a request.
//  Misaligned: in IDLE with pc_in[1:0]!=0, !flush_in and credit_ok: no memory request; push
//   {NOP_INSTR, pc_in, 1}; pc_accept_out=1. In REQ, wait until the outstanding request completes.
//  Latency: the push edge is the ack edge; instr_valid_out rises the cycle after.
//   Empty FIFO: pc_accept at cycle N, ack at N+1 at earliest, instr_valid at N+2.
//  FIFO: wr/rd pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH. Simultaneous push+pop
//   leaves count unchanged. Push can never hit full, because credit guarantees a slot.
//   Head outputs always show the entry at rd_ptr.
//  flush_in (takes priority over all else): FIFO emptied at the edge; pc_accept_out=0 that cycle.
//   - REQ & !ack: go to DRAIN, keep imem_req_out high; the data returned on ack is discarded,
//     then IDLE.
//   - REQ & ack: discard the data, go to IDLE.
//   - flush_in held in DRAIN: stay in DRAIN.
//   - pop in the flush cycle is ignored.
//  Reset mid-transaction: outputs return to reset values immediately. The memory side treats
//   rst_n as aborting any request.
// STRUCTURE
//  Shared package msrv_32_pkg: state encoding (IDLE/REQ/DRAIN), NOP_INSTR, XLEN=32.
//  Sub-module msrv_32_fetch_fifo: parameterised FIFO_DEPTH x 65b {misalign,pc,instr}; exposes
//   push, pop, clear, count, head.
//  Top level: FSM, credit logic and tag register only.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> req=0, addr=0, valid=0, pc_accept=0 without waiting for a clock;
//    release -> IDLE.
//  2 Zero-wait stream: pc 0,4,8,12, ack the cycle after each req, ready=1 -> instr_valid every
//    cycle from cycle 2; instr_pc_out 0,4,8,12 in order.
//  3 Wait states: ack 3 cycles after req at addr 0x100 -> addr held at 0x100 all 3 cycles;
//    pc_accept=0 until ack.
//  4 Backpressure: ready=0, DEPTH=2 -> exactly 2 pushes, then pc_accept=0 and req=0;
//    ready=1 for 1 cycle -> exactly one new fetch issued.
//  5 Flush in flight: flush while REQ, ack 2 cycles later with 0xDEADBEEF -> FIFO empty,
//    word never appears; next fetch uses the redirected pc_in.
//  6 Misaligned: pc_in=0x102 -> no imem_req; instr_out=0x00000013, instr_pc_out=0x102,
//    instr_misalign_out=1.

Source files
------------

// File: rtl/msrv_32_pkg.sv
// Shared definitions for the msrv_32 fetch path: widths, fetch FSM encoding,
// the default NOP word and the layout of a buffered fetch entry.
package msrv_32_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            misalign;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/msrv_32_fetch_fifo.sv
// Fetch buffer: DEPTH x {misalign,pc,instr} ring with synchronous clear.
// The head always shows the entry at the read pointer, valid or not.
module msrv_32_fetch_fifo
  import msrv_32_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  fetch_entry_t           entry_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW:0]    count_q;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/msrv_32_ifetch_unit.sv
// Instruction fetch: one outstanding req/ack transaction to instruction memory,
// credit-based issue into a small fetch buffer, and flush with in-flight drain.
module msrv_32_ifetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = msrv_32_pkg::NOP_INSTR
) (
  input  logic        ms_risc32_mp_clk_in,
  input  logic        ms_risc32_mp_rst_n_in,
  input  logic [31:0] pc_in,
  output logic        pc_accept_out,
  input  logic        flush_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_misalign_out
);

  import msrv_32_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_W = SW'(FIFO_DEPTH);

  fetch_state_e    state_q;
  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] tag_q;

  logic [CW-1:0]   count;
  logic [SW-1:0]   slots;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop, credit_ok, aligned, ack_live;
  logic            issue, mis_push, push, fifo_pop;

  assign instr_valid_out = (count != '0);
  assign pop             = instr_valid_out & instr_ready_in;

  // An outstanding request already owns a slot in the buffer
  assign slots     = {1'b0, count} + {{CW{1'b0}}, req_q} - {{CW{1'b0}}, pop};
  assign credit_ok = (slots < DEPTH_W);
  assign aligned   = (pc_in[1:0] == 2'b00);
  assign ack_live  = (state_q == ST_REQ) & imem_ack_in;

  // Gated with reset so the PC mux never advances while the unit is held in reset
  assign issue    = ms_risc32_mp_rst_n_in & ~flush_in & credit_ok & aligned &
                    ((state_q == ST_IDLE) | ack_live);
  assign mis_push = ms_risc32_mp_rst_n_in & ~flush_in & credit_ok & ~aligned &
                    (state_q == ST_IDLE);

  assign pc_accept_out = issue | mis_push;
  assign push          = (ack_live & ~flush_in) | mis_push;
  assign fifo_pop      = pop & ~flush_in;

  always_comb begin
    push_entry = '0;
    if (mis_push) begin
      push_entry.misalign = 1'b1;
      push_entry.pc       = pc_in;
      push_entry.instr    = NOP_INSTR;
    end else begin
      push_entry.misalign = 1'b0;
      push_entry.pc       = tag_q;
      push_entry.instr    = imem_rdata_in;
    end
  end

  always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_n_in) begin
    if (!ms_risc32_mp_rst_n_in) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= {pc_in[31:2], 2'b00};
            tag_q   <= pc_in;
          end
        end
        ST_REQ: begin
          if (imem_ack_in) begin
            if (issue) begin
              addr_q <= {pc_in[31:2], 2'b00};
              tag_q  <= pc_in;
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end else if (flush_in) begin
            // request cannot be withdrawn; keep it up and throw its data away
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem_ack_in) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  msrv_32_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ms_risc32_mp_clk_in),
    .rst_ni  (ms_risc32_mp_rst_n_in),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .clear_i (flush_in),
    .entry_i (push_entry),
    .count_o (count),
    .head_o  (head)
  );

  assign imem_req_out       = req_q;
  assign imem_addr_out      = addr_q;
  assign instr_out          = head.instr;
  assign instr_pc_out       = head.pc;
  assign instr_misalign_out = head.misalign;

endmodule

// File: tb/tb_msrv_32_ifetch_unit.sv
// Self-checking bench for msrv_32_ifetch_unit: a transaction-level model
// (outstanding flag + entry queue) checked every cycle, plus directed scenarios.
module tb_msrv_32_ifetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;
  logic        pc_accept, req, valid, mis;
  logic [31:0] addr, instr, ipc;

  always #5 clk = ~clk;

  msrv_32_ifetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .ms_risc32_mp_clk_in   (clk),
    .ms_risc32_mp_rst_n_in (rst_n),
    .pc_in                 (pc),
    .pc_accept_out         (pc_accept),
    .flush_in              (flush),
    .imem_req_out          (req),
    .imem_addr_out         (addr),
    .imem_ack_in           (ack),
    .imem_rdata_in         (rdata),
    .instr_valid_out       (valid),
    .instr_ready_in        (ready),
    .instr_out             (instr),
    .instr_pc_out          (ipc),
    .instr_misalign_out    (mis)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        q[$];
  bit          m_out, m_drain, m_acc;
  logic [31:0] m_addr, m_tag;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out   = 0;
    m_drain = 0;
    m_acc   = 0;
    m_addr  = '0;
    m_tag   = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model
  task automatic step(input bit f, input bit a, input bit r,
                      input logic [31:0] p, input logic [31:0] d);
    bit   mv, mpop, credit, al, acc;
    int   slots;
    ent_t e;
    @(posedge clk);
    #1;
    flush = f; ack = a; ready = r; pc = p; rdata = d;
    @(negedge clk);
    mv     = (q.size() != 0);
    mpop   = mv && r;
    slots  = q.size() + int'(m_out) - int'(mpop);
    credit = (slots < DEPTH);
    al     = (p[1:0] == 2'b00);
    if (f || !credit || m_drain) acc = 0;
    else if (al)                 acc = !m_out || a;
    else                         acc = !m_out;
    m_acc = acc;
    chk("pc_accept", 32'(pc_accept), 32'(acc));
    chk("imem_req", 32'(req), 32'(m_out));
    if (m_out) chk("imem_addr", addr, m_addr);
    chk("instr_valid", 32'(valid), 32'(mv));
    if (mv) begin
      chk("instr", instr, q[0].instr);
      chk("instr_pc", ipc, q[0].pc);
      chk("instr_misalign", 32'(mis), 32'(q[0].mis));
    end
    if (f) begin
      q.delete();
      if (m_out && a) begin
        m_out = 0; m_drain = 0;
      end else if (m_out) begin
        m_drain = 1;
      end
    end else begin
      if (mpop) void'(q.pop_front());
      if (m_out && a) begin
        if (!m_drain) begin
          e.instr = d; e.pc = m_tag; e.mis = 0;
          q.push_back(e);
        end
        m_out = 0; m_drain = 0;
      end
      if (acc) begin
        if (al) begin
          m_out = 1; m_addr = {p[31:2], 2'b00}; m_tag = p;
        end else begin
          e.instr = NOP; e.pc = p; e.mis = 1;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic settle();
    step(1'b1, m_out, 1'b1, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] p;
    int          acc_cnt;
    bit          f, a, r;

    model_reset();
    #2;
    chk("reset_req", 32'(req), 32'h0);
    chk("reset_addr", addr, 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_accept", 32'(pc_accept), 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", ipc, 32'h0);
    chk("reset_misalign", 32'(mis), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // zero-wait stream: 0,4,8,12 delivered back to back
    step(0, 0, 1, 32'h0, 32'h0);
    chk("zw_accept0", 32'(pc_accept), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 1, 32'(4 * i), 32'hA000_0000 + 32'(i - 1));
      if (i >= 2) begin
        chk("zw_valid", 32'(valid), 32'h1);
        chk("zw_instr_pc", ipc, 32'(4 * (i - 2)));
        chk("zw_instr", instr, 32'hA000_0000 + 32'(i - 2));
      end
    end
    settle();

    // wait states: request at 0x100 held for three cycles
    step(0, 0, 1, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h104, 32'h0);
      chk("ws_req", 32'(req), 32'h1);
      chk("ws_addr", addr, 32'h100);
      chk("ws_accept", 32'(pc_accept), 32'h0);
    end
    step(0, 1, 1, 32'h104, 32'h1234_5678);
    chk("ws_accept_on_ack", 32'(pc_accept), 32'h1);
    settle();

    // backpressure: buffer fills after exactly two fetches
    p = 32'h400; acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, m_out, 0, p, $urandom);
      if (pc_accept) acc_cnt++;
      if (m_acc) p += 4;
    end
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    chk("bp_req_idle", 32'(req), 32'h0);
    chk("bp_accept_blocked", 32'(pc_accept), 32'h0);
    chk("bp_valid", 32'(valid), 32'h1);
    acc_cnt = 0;
    step(0, 0, 1, p, 32'h0);
    if (pc_accept) acc_cnt++;
    if (m_acc) p += 4;
    for (int i = 0; i < 4; i++) begin
      step(0, m_out, 0, p, $urandom);
      if (pc_accept) acc_cnt++;
      if (m_acc) p += 4;
    end
    chk("bp_one_more_fetch", 32'(acc_cnt), 32'd1);
    settle();

    // flush while a request is in flight
    step(0, 0, 1, 32'h40, 32'h0);
    step(1, 0, 1, 32'h44, 32'h0);
    step(0, 0, 1, 32'h200, 32'h0);
    chk("fl_drain_req", 32'(req), 32'h1);
    chk("fl_drain_accept", 32'(pc_accept), 32'h0);
    step(0, 1, 1, 32'h200, 32'hDEAD_BEEF);
    step(0, 0, 1, 32'h200, 32'h0);
    chk("fl_no_stale", 32'(valid), 32'h0);
    chk("fl_redirect_accept", 32'(pc_accept), 32'h1);
    step(0, 1, 1, 32'h204, 32'h1111_1111);
    chk("fl_redirect_addr", addr, 32'h200);
    step(0, 0, 1, 32'h208, 32'h0);
    chk("fl_new_instr", instr, 32'h1111_1111);
    chk("fl_new_pc", ipc, 32'h200);
    settle();

    // misaligned pc yields a NOP without touching memory
    step(0, 0, 0, 32'h102, 32'h0);
    chk("ma_accept", 32'(pc_accept), 32'h1);
    chk("ma_no_req", 32'(req), 32'h0);
    step(0, 0, 0, 32'h106, 32'h0);
    chk("ma_no_req2", 32'(req), 32'h0);
    chk("ma_instr", instr, NOP);
    chk("ma_pc", ipc, 32'h102);
    chk("ma_flag", 32'(mis), 32'h1);
    settle();

    // asynchronous reset with a request outstanding
    step(0, 0, 1, 32'h300, 32'h0);
    @(posedge clk);
    #1;
    chk("ar_req_before", 32'(req), 32'h1);
    rst_n = 1'b0; flush = 1'b1; ack = 1'b0; ready = 1'b0;
    #1;
    chk("ar_req", 32'(req), 32'h0);
    chk("ar_addr", addr, 32'h0);
    chk("ar_valid", 32'(valid), 32'h0);
    chk("ar_accept", 32'(pc_accept), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // randomized traffic
    p = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      f = ($urandom_range(0, 15) == 0);
      a = m_out && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) != 0);
      step(f, a, r, p, $urandom);
      if (f) begin
        p = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) p[1:0] = 2'($urandom_range(1, 3));
      end else if (m_acc) begin
        p += 4;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
